// File: rtl/apb_cmd_master_if.sv
// rtl/apb_cmd_master_if.sv - signal bundle between a command source, apb_cmd_master and an APB slave
//
// master modport : the apb_cmd_master view (takes commands, drives APB, returns responses)
// slave modport  : the surrounding environment view (issues commands, answers APB, consumes responses)
// Signals: cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata, rsp_valid/rsp_ready/rsp_rdata/rsp_err,
//          apb_psel/apb_penable/apb_pwrite/apb_paddr/apb_pwdata/apb_prdata/apb_pready/apb_pslverr, busy
interface apb_cmd_master_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              apb_psel;
    logic              apb_penable;
    logic              apb_pwrite;
    logic [ADDR_W-1:0] apb_paddr;
    logic [DATA_W-1:0] apb_pwdata;
    logic [DATA_W-1:0] apb_prdata;
    logic              apb_pready;
    logic              apb_pslverr;

    logic              busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
        input  apb_prdata, apb_pready, apb_pslverr,
        output busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
        output apb_prdata, apb_pready, apb_pslverr,
        input  busy
    );
endinterface

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - command-driven APB initiator with command FIFO and response port
//
// Ports:
//   apb_pclk : clock, rising edge
//   rst      : synchronous reset, active-high
//   bus      : apb_cmd_master_if.master (command in, response out, APB master side, busy)
// Optional feature: define APB_MASTER_TIMEOUT_EN to add the TIMEOUT parameter and abort
// ACCESS phases that wait TIMEOUT cycles without pready.
module apb_cmd_master #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
`ifdef APB_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 255
`endif
) (
    input logic              apb_pclk,
    input logic              rst,
    apb_cmd_master_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Command FIFO
    cmd_t             fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    cmd_t             cmd_in, cmd_head;

    // Registered APB and response outputs
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] wait_cnt_q, wait_cnt_d;
`endif

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = bus.cmd_valid && !fifo_full;
    assign cmd_in     = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
    assign cmd_head   = fifo_mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_head.write;
                    paddr_d   = cmd_head.addr;
                    pwdata_d  = cmd_head.wdata;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ACCESS: begin
                // pready wins over a timeout landing in the same cycle
                if (bus.apb_pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : bus.apb_prdata;
                    rsp_err_d   = bus.apb_pslverr;
                    state_d     = RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    // This wait cycle brings the count to TIMEOUT: abort
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge apb_pclk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge apb_pclk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    // Storage needs no reset; the pointers define what is valid
    always_ff @(posedge apb_pclk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    assign bus.cmd_ready   = !fifo_full;
    assign bus.apb_psel    = psel_q;
    assign bus.apb_penable = penable_q;
    assign bus.apb_pwrite  = pwrite_q;
    assign bus.apb_paddr   = paddr_q;
    assign bus.apb_pwdata  = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.busy        = !fifo_empty || (state_q != IDLE);
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - self-checking bench for apb_cmd_master against a transaction-level model
module tb_apb_cmd_master;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int TO     = 8;

    typedef struct {
        bit          write;
        logic [19:0] addr;
        logic [7:0]  wdata;
    } cmd_s;

    typedef struct {
        int         waits;
        logic [7:0] rdata;
        bit         err;
    } plan_s;

    typedef struct {
        logic [7:0] rdata;
        bit         err;
    } rsp_s;

    logic apb_pclk = 1'b0;
    logic rst      = 1'b1;
    int   cyc      = 0;

    apb_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_cmd_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .FIFO_DEPTH(DEPTH)
`ifdef APB_MASTER_TIMEOUT_EN
        ,
        .TIMEOUT(TO)
`endif
    ) dut (
        .apb_pclk(apb_pclk),
        .rst(rst),
        .bus(bus)
    );

    always #5 apb_pclk = ~apb_pclk;
    always @(posedge apb_pclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Transaction-level reference model
    cmd_s  exp_apb_q[$];
    plan_s plan_q[$];
    rsp_s  exp_rsp_q[$];

    function automatic rsp_s model_rsp(input cmd_s c, input plan_s p);
        rsp_s r;
        bit   timed_out;
        timed_out = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        timed_out = (p.waits >= TO);
`endif
        if (timed_out) begin
            r.rdata = 8'h00;
            r.err   = 1'b1;
        end else begin
            r.rdata = c.write ? 8'h00 : p.rdata;
            r.err   = p.err;
        end
        return r;
    endfunction

    task automatic flush_model();
        exp_apb_q.delete();
        plan_q.delete();
        exp_rsp_q.delete();
    endtask

    // APB slave: answers each ACCESS phase according to its plan entry
    bit    in_acc = 1'b0;
    int    acc_n  = 0;
    plan_s cur_plan;

    initial begin
        bus.apb_pready  = 1'b0;
        bus.apb_prdata  = 8'h00;
        bus.apb_pslverr = 1'b0;
        forever begin
            @(posedge apb_pclk);
            #1;
            if (bus.apb_psel && bus.apb_penable) begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    acc_n  = 0;
                    if (plan_q.size() > 0) cur_plan = plan_q.pop_front();
                    else cur_plan = '{waits: 0, rdata: 8'h00, err: 1'b0};
                end
                bus.apb_pready  = (acc_n >= cur_plan.waits);
                bus.apb_prdata  = cur_plan.rdata;
                bus.apb_pslverr = cur_plan.err;
                acc_n++;
            end else begin
                in_acc          = 1'b0;
                bus.apb_pready  = 1'($urandom_range(0, 1));
                bus.apb_prdata  = 8'($urandom);
                bus.apb_pslverr = 1'($urandom_range(0, 1));
            end
        end
    end

    // Response-ready driver
    bit rr_rand  = 1'b0;
    bit rr_fixed = 1'b1;

    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge apb_pclk);
            #2;
            bus.rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
        end
    end

    // Monitor: protocol and response checks on the falling edge
    bit          prev_acc   = 1'b0;
    bit          prev_setup = 1'b0;
    bit          prev_rv    = 1'b0;
    logic [19:0] prev_addr  = '0;
    int          psel_cycles = 0;
    int          pen_cycles  = 0;
    int          done_cnt    = 0;
    int          rise_cyc    = -1;
    cmd_s        mon_cmd;
    rsp_s        mon_rsp;

    always @(negedge apb_pclk) begin
        if (!rst) begin
            if (bus.apb_psel) psel_cycles++;
            if (bus.apb_penable) pen_cycles++;
            if (bus.apb_psel && bus.apb_penable) begin
                if (!prev_acc) begin
                    check_eq("setup_before_access", 32'(prev_setup), 32'd1);
                    if (exp_apb_q.size() == 0) begin
                        check_eq("apb_unexpected_transfer", 32'd1, 32'd0);
                    end else begin
                        mon_cmd = exp_apb_q.pop_front();
                        check_eq("paddr", 32'(bus.apb_paddr), 32'(mon_cmd.addr));
                        check_eq("pwrite", 32'(bus.apb_pwrite), 32'(mon_cmd.write));
                        if (mon_cmd.write) check_eq("pwdata", 32'(bus.apb_pwdata), 32'(mon_cmd.wdata));
                    end
                end else begin
                    check_eq("paddr_stable", 32'(bus.apb_paddr), 32'(prev_addr));
                end
            end
            if (bus.rsp_valid) check_eq("no_transfer_while_rsp", 32'(bus.apb_psel), 32'd0);
            if (bus.rsp_valid && !prev_rv) rise_cyc = cyc;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_rsp_q.size() == 0) begin
                    check_eq("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_rsp = exp_rsp_q.pop_front();
                    check_eq("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_rsp.rdata));
                    check_eq("rsp_err", 32'(bus.rsp_err), 32'(mon_rsp.err));
                end
                done_cnt++;
            end
            prev_acc   = bus.apb_psel && bus.apb_penable;
            prev_setup = bus.apb_psel && !bus.apb_penable;
            prev_addr  = bus.apb_paddr;
            prev_rv    = bus.rsp_valid;
        end else begin
            prev_acc   = 1'b0;
            prev_setup = 1'b0;
            prev_rv    = 1'b0;
        end
    end

    task automatic step();
        @(posedge apb_pclk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Offer one command; returns the edge number of the handshake (-1 if never accepted)
    task automatic send_cmd(input bit w, input logic [19:0] a, input logic [7:0] d,
                            input int waits, input logic [7:0] rd, input bit er, output int hs);
        cmd_s  c;
        plan_s p;
        int    budget;
        budget        = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        while (!bus.cmd_ready && budget < 500) begin
            step();
            budget++;
        end
        if (!bus.cmd_ready) begin
            check_eq("cmd_accept_timeout", 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
            hs = -1;
        end else begin
            hs = cyc + 1;
            c  = '{write: w, addr: a, wdata: d};
            p  = '{waits: waits, rdata: rd, err: er};
            exp_apb_q.push_back(c);
            plan_q.push_back(p);
            exp_rsp_q.push_back(model_rsp(c, p));
            step();
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int b;
        b = 0;
        while ((exp_rsp_q.size() != 0 || bus.busy) && b < 3000) begin
            step();
            b++;
        end
        check_eq(tag, 32'(exp_rsp_q.size()), 32'd0);
    endtask

    int hs;
    int hs6;
    int done0;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;

        // Reset state
        steps(2);
        check_eq("rst_psel", 32'(bus.apb_psel), 32'd0);
        check_eq("rst_penable", 32'(bus.apb_penable), 32'd0);
        check_eq("rst_pwrite", 32'(bus.apb_pwrite), 32'd0);
        check_eq("rst_paddr", 32'(bus.apb_paddr), 32'd0);
        check_eq("rst_pwdata", 32'(bus.apb_pwdata), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        step();
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Single write, no wait states
        psel_cycles = 0;
        pen_cycles  = 0;
        rise_cyc    = -1;
        send_cmd(1'b1, 20'h00010, 8'hA5, 0, 8'h5E, 1'b0, hs);
        drain("write_drain");
        check_eq("write_latency", 32'(rise_cyc - hs), 32'd3);
        check_eq("write_psel_cycles", 32'(psel_cycles), 32'd2);
        check_eq("write_penable_cycles", 32'(pen_cycles), 32'd1);

        // Read with three wait states
        pen_cycles = 0;
        rise_cyc   = -1;
        send_cmd(1'b0, 20'h00014, 8'h00, 3, 8'h3C, 1'b0, hs);
        drain("read_wait_drain");
        check_eq("read_wait_latency", 32'(rise_cyc - hs), 32'd6);
        check_eq("read_wait_access_cycles", 32'(pen_cycles), 32'd4);

        // Slave error followed by a queued command
        send_cmd(1'b0, 20'h00020, 8'h00, 0, 8'h77, 1'b1, hs);
        send_cmd(1'b1, 20'h00024, 8'h19, 1, 8'hFF, 1'b0, hs);
        drain("slverr_drain");

        // FIFO fill with the response port stalled
        rr_fixed = 1'b0;
        step();
        done0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            send_cmd(1'($urandom_range(0, 1)), 20'h00100 + 20'(i), 8'($urandom), 0, 8'($urandom), 1'b0, hs);
        end
        check_eq("fifo_full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        fork
            send_cmd(1'b0, 20'h00105, 8'h00, 0, 8'hC3, 1'b0, hs6);
        join_none
        steps(10);
        check_eq("stall_rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
        check_eq("stall_sixth_not_accepted", 32'(exp_rsp_q.size()), 32'd5);
        rr_fixed = 1'b1;
        wait fork;
        drain("fifo_full_drain");
        check_eq("fifo_full_all_done", 32'(done_cnt - done0), 32'd6);

`ifdef APB_MASTER_TIMEOUT_EN
        // Completion on the last allowed wait cycle, then a stuck slave
        rise_cyc = -1;
        send_cmd(1'b0, 20'h00200, 8'h00, TO - 1, 8'h5A, 1'b0, hs);
        drain("late_pready_drain");
        check_eq("late_pready_latency", 32'(rise_cyc - hs), 32'(TO + 2));
        rise_cyc = -1;
        send_cmd(1'b0, 20'h00204, 8'h00, 100000, 8'h99, 1'b0, hs);
        drain("timeout_drain");
        check_eq("timeout_latency", 32'(rise_cyc - hs), 32'(TO + 2));
`else
        // Stuck slave: ACCESS never ends on its own
        send_cmd(1'b0, 20'h00204, 8'h00, 100000, 8'h99, 1'b0, hs);
        steps(1000);
        check_eq("stuck_still_access", 32'(bus.apb_psel && bus.apb_penable), 32'd1);
        check_eq("stuck_no_rsp", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b1;
        step();
        flush_model();
        rst = 1'b0;
        step();
`endif

        // Reset during ACCESS with two commands queued
        send_cmd(1'b1, 20'h00300, 8'h11, 50, 8'h00, 1'b0, hs);
        send_cmd(1'b1, 20'h00304, 8'h22, 0, 8'h00, 1'b0, hs);
        send_cmd(1'b0, 20'h00308, 8'h00, 0, 8'h33, 1'b0, hs);
        begin
            int b;
            b = 0;
            while (!(bus.apb_psel && bus.apb_penable) && b < 50) begin
                step();
                b++;
            end
        end
        check_eq("mid_reset_in_access", 32'(bus.apb_psel && bus.apb_penable), 32'd1);
        rst = 1'b1;
        step();
        check_eq("mid_reset_psel", 32'(bus.apb_psel), 32'd0);
        check_eq("mid_reset_penable", 32'(bus.apb_penable), 32'd0);
        check_eq("mid_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("mid_reset_busy", 32'(bus.busy), 32'd0);
        flush_model();
        rst = 1'b0;
        psel_cycles = 0;
        steps(30);
        check_eq("mid_reset_no_later_transfer", 32'(psel_cycles), 32'd0);
        check_eq("mid_reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Randomized traffic with random response back-pressure
        rr_rand = 1'b1;
        done0   = done_cnt;
        for (int i = 0; i < 40; i++) begin
            send_cmd(1'($urandom_range(0, 1)), 20'($urandom), 8'($urandom),
                     int'($urandom_range(0, 4)), 8'($urandom), ($urandom_range(0, 3) == 0), hs);
            if ($urandom_range(0, 3) == 0) steps(int'($urandom_range(1, 6)));
        end
        drain("random_drain");
        check_eq("random_done_count", 32'(done_cnt - done0), 32'd40);
        check_eq("random_end_busy", 32'(bus.busy), 32'd0);
        rr_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
